// File: rtl/alu_opa_bypass_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_opa_bypass_stage
// Purpose  : Registered ALU operand-A select stage. It chooses among rs1,
//            imm_u, imm_z, pc and zero. rs1 is resolved through a
//            priority bypass network, with a load-use interlock. The result
//            is held in a single-entry valid/ready pipeline register that
//            supports flush.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clock            in   rising-edge clock
//   reset            in   synchronous active-high reset
//   io_in_valid      in   upstream request valid
//   io_in_ready      out  request accepted this cycle (combinational)
//   io_rs1_addr      in   rs1 register index
//   io_rs1           in   register-file rs1 value
//   io_pc            in   instruction PC
//   io_imm_u         in   U-type immediate
//   io_imm_z         in   zero-extended CSR immediate
//   io_rs1_mux_sel   in   0 rs1, 1 imm_u, 2 imm_z, 3 pc, 4 zero, 5-7 rs1
//   io_byp_valid     in   per-channel pending write
//   io_byp_busy      in   per-channel data not yet available
//   io_byp_addr      in   per-channel destination index (5 bits each)
//   io_byp_data      in   per-channel forwarded value (XLEN bits each)
//   io_flush         in   kill held entry and incoming request
//   io_out_valid     out  io_to_alu_a valid
//   io_out_ready     in   ALU consumes the output
//   io_to_alu_a      out  registered operand A
//   io_out_bypassed  out  held operand came from a bypass channel
//   io_stall_cnt     out  saturating count of interlock stall cycles
// ============================================================================
module alu_opa_bypass_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_BYP = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_in_valid,
    output logic                    io_in_ready,
    input  logic [4:0]              io_rs1_addr,
    input  logic [XLEN-1:0]         io_rs1,
    input  logic [XLEN-1:0]         io_pc,
    input  logic [XLEN-1:0]         io_imm_u,
    input  logic [XLEN-1:0]         io_imm_z,
    input  logic [2:0]              io_rs1_mux_sel,
    input  logic [NUM_BYP-1:0]      io_byp_valid,
    input  logic [NUM_BYP-1:0]      io_byp_busy,
    input  logic [5*NUM_BYP-1:0]    io_byp_addr,
    input  logic [XLEN*NUM_BYP-1:0] io_byp_data,
    input  logic                    io_flush,
    output logic                    io_out_valid,
    input  logic                    io_out_ready,
    output logic [XLEN-1:0]         io_to_alu_a,
    output logic                    io_out_bypassed,
    output logic [CNT_W-1:0]        io_stall_cnt
);

    // Source select encodings
    localparam logic [2:0] c_SEL_RS1   = 3'd0;
    localparam logic [2:0] c_SEL_IMM_U = 3'd1;
    localparam logic [2:0] c_SEL_IMM_Z = 3'd2;
    localparam logic [2:0] c_SEL_PC    = 3'd3;
    localparam logic [2:0] c_SEL_ZERO  = 3'd4;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic              r_out_valid;
    logic [XLEN-1:0]   r_to_alu_a;
    logic              r_out_bypassed;
    logic [CNT_W-1:0]  r_stall_cnt;

    // ------------------------------------------------------------------
    // Bypass match per channel. x0 is hard-wired zero in the register
    // file, so it is never forwarded even if a channel claims to write it.
    // ------------------------------------------------------------------
    logic [NUM_BYP-1:0] w_match;

    generate
        for (genvar gi = 0; gi < NUM_BYP; gi++) begin : g_match
            assign w_match[gi] = io_byp_valid[gi]
                              && (io_byp_addr[5*gi +: 5] == io_rs1_addr)
                              && (io_rs1_addr != 5'd0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Priority resolution: walk from the oldest channel to the youngest
    // so that the lowest-index match is the last assignment and wins.
    // Only the winner's busy bit matters; an older busy channel hidden
    // behind a ready younger one must not stall.
    // ------------------------------------------------------------------
    logic            w_hit;
    logic            w_hit_busy;
    logic [XLEN-1:0] w_rs1_eff;

    always_comb begin
        w_hit      = 1'b0;
        w_hit_busy = 1'b0;
        w_rs1_eff  = io_rs1;
        for (int i = NUM_BYP - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit      = 1'b1;
                w_hit_busy = io_byp_busy[i];
                w_rs1_eff  = io_byp_data[XLEN*i +: XLEN];
            end
        end
    end

    // ------------------------------------------------------------------
    // Source selection. Codes 5-7 are unused and fall back to rs1.
    // ------------------------------------------------------------------
    logic            w_sel_rs1;
    logic [XLEN-1:0] w_src;

    assign w_sel_rs1 = (io_rs1_mux_sel == c_SEL_RS1) || (io_rs1_mux_sel > c_SEL_ZERO);

    always_comb begin
        w_src = w_rs1_eff;
        case (io_rs1_mux_sel)
            c_SEL_IMM_U: w_src = io_imm_u;
            c_SEL_IMM_Z: w_src = io_imm_z;
            c_SEL_PC:    w_src = io_pc;
            c_SEL_ZERO:  w_src = '0;
            default:     w_src = w_rs1_eff;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_interlock;
    logic w_accept;
    logic w_consume;

    assign w_interlock = w_sel_rs1 && w_hit && w_hit_busy;
    assign io_in_ready = !reset && !io_flush && !w_interlock
                      && (!r_out_valid || io_out_ready);
    assign w_accept    = io_in_valid && io_in_ready;
    assign w_consume   = r_out_valid && io_out_ready;

    // ------------------------------------------------------------------
    // Output pipeline register. Flush has priority over accept (ready is
    // already low during flush, so this ordering only documents intent).
    // On a plain drain only the valid bit drops; the data stays put.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_to_alu_a     <= '0;
            r_out_bypassed <= 1'b0;
        end else if (io_flush) begin
            r_out_valid    <= 1'b0;
            r_out_bypassed <= 1'b0;
        end else if (w_accept) begin
            r_out_valid    <= 1'b1;
            r_to_alu_a     <= w_src;
            r_out_bypassed <= w_sel_rs1 && w_hit;
        end else if (w_consume) begin
            r_out_valid    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall counter: counts only cycles where a real request
    // is blocked by the interlock; a flushed request is not a stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (io_in_valid && w_interlock && !io_flush
                     && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign io_out_valid    = r_out_valid;
    assign io_to_alu_a     = r_to_alu_a;
    assign io_out_bypassed = r_out_bypassed;
    assign io_stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_opa_bypass_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_opa_bypass_stage
// Purpose  : Directed self-checking bench for alu_opa_bypass_stage. A second
//            instance with a 4-bit stall counter shares all inputs and is
//            used for the saturation scenario.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_opa_bypass_stage;

    localparam int XLEN    = 32;
    localparam int NUM_BYP = 2;

    logic                    clock;
    logic                    reset;
    logic                    in_valid;
    logic [4:0]              rs1_addr;
    logic [XLEN-1:0]         rs1;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         imm_u;
    logic [XLEN-1:0]         imm_z;
    logic [2:0]              sel;
    logic [NUM_BYP-1:0]      byp_valid;
    logic [NUM_BYP-1:0]      byp_busy;
    logic [5*NUM_BYP-1:0]    byp_addr;
    logic [XLEN*NUM_BYP-1:0] byp_data;
    logic                    flush;
    logic                    out_ready;

    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] to_alu_a;
    logic            out_bypassed;
    logic [15:0]     stall_cnt;

    logic            in_ready4;
    logic            out_valid4;
    logic [XLEN-1:0] to_alu_a4;
    logic            out_bypassed4;
    logic [3:0]      stall_cnt4;

    int checks = 0;
    int errors = 0;

    alu_opa_bypass_stage #(.XLEN(XLEN), .NUM_BYP(NUM_BYP), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in_ready(in_ready),
        .io_rs1_addr(rs1_addr), .io_rs1(rs1), .io_pc(pc), .io_imm_u(imm_u),
        .io_imm_z(imm_z), .io_rs1_mux_sel(sel), .io_byp_valid(byp_valid),
        .io_byp_busy(byp_busy), .io_byp_addr(byp_addr), .io_byp_data(byp_data),
        .io_flush(flush), .io_out_valid(out_valid), .io_out_ready(out_ready),
        .io_to_alu_a(to_alu_a), .io_out_bypassed(out_bypassed), .io_stall_cnt(stall_cnt)
    );

    alu_opa_bypass_stage #(.XLEN(XLEN), .NUM_BYP(NUM_BYP), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in_ready(in_ready4),
        .io_rs1_addr(rs1_addr), .io_rs1(rs1), .io_pc(pc), .io_imm_u(imm_u),
        .io_imm_z(imm_z), .io_rs1_mux_sel(sel), .io_byp_valid(byp_valid),
        .io_byp_busy(byp_busy), .io_byp_addr(byp_addr), .io_byp_data(byp_data),
        .io_flush(flush), .io_out_valid(out_valid4), .io_out_ready(out_ready),
        .io_to_alu_a(to_alu_a4), .io_out_bypassed(out_bypassed4), .io_stall_cnt(stall_cnt4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid  = 1'b0;
        rs1_addr  = 5'd0;
        rs1       = '0;
        pc        = '0;
        imm_u     = '0;
        imm_z     = '0;
        sel       = 3'd0;
        byp_valid = '0;
        byp_busy  = '0;
        byp_addr  = '0;
        byp_data  = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (to_alu_a !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", to_alu_a); end
        checks++; if (out_bypassed !== 1'b0) begin errors++; $display("FAIL reset_byp: got %b want 0", out_bypassed); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        reset = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_source_select();
        logic [XLEN-1:0] exp_v [8];
        exp_v[0] = 32'h11;  exp_v[1] = 32'h2000; exp_v[2] = 32'h1F; exp_v[3] = 32'h80;
        exp_v[4] = 32'h0;   exp_v[5] = 32'h11;   exp_v[6] = 32'h11; exp_v[7] = 32'h11;
        clear_inputs();
        rs1 = 32'h11; imm_u = 32'h2000; imm_z = 32'h1F; pc = 32'h80;
        rs1_addr = 5'd3;
        in_valid = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            checks++; if (out_valid !== 1'b1 || to_alu_a !== exp_v[s] || out_bypassed !== 1'b0) begin
                errors++; $display("FAIL src_sel%0d: got v=%b d=%h b=%b want v=1 d=%h b=0", s, out_valid, to_alu_a, out_bypassed, exp_v[s]);
            end
        end
        // Drain: valid drops, data retained.
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || to_alu_a !== 32'h11) begin
            errors++; $display("FAIL drain: got v=%b d=%h want v=0 d=00000011", out_valid, to_alu_a);
        end
    endtask

    task automatic test_bypass();
        clear_inputs();
        rs1 = 32'h11; rs1_addr = 5'd5; sel = 3'd0; in_valid = 1'b1;
        byp_valid = 2'b11; byp_addr = {5'd5, 5'd5}; byp_data = {32'hBBBB, 32'hAAAA};
        tick();
        checks++; if (to_alu_a !== 32'hAAAA || out_bypassed !== 1'b1) begin
            errors++; $display("FAIL byp_prio: got d=%h b=%b want d=0000aaaa b=1", to_alu_a, out_bypassed);
        end
        byp_valid = 2'b10;
        tick();
        checks++; if (to_alu_a !== 32'hBBBB || out_bypassed !== 1'b1) begin
            errors++; $display("FAIL byp_ch1: got d=%h b=%b want d=0000bbbb b=1", to_alu_a, out_bypassed);
        end
        rs1_addr = 5'd0; byp_valid = 2'b11; byp_addr = {5'd0, 5'd0};
        tick();
        checks++; if (to_alu_a !== 32'h11 || out_bypassed !== 1'b0) begin
            errors++; $display("FAIL byp_x0: got d=%h b=%b want d=00000011 b=0", to_alu_a, out_bypassed);
        end
        // Older channel busy behind a ready younger winner: no interlock.
        rs1_addr = 5'd5; byp_addr = {5'd5, 5'd5}; byp_busy = 2'b10;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL byp_lowbusy_ready: got %b want 1", in_ready); end
        tick();
        checks++; if (to_alu_a !== 32'hAAAA || out_bypassed !== 1'b1) begin
            errors++; $display("FAIL byp_lowbusy: got d=%h b=%b want d=0000aaaa b=1", to_alu_a, out_bypassed);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_interlock();
        clear_inputs();
        pulse_reset();
        rs1 = 32'h11; imm_u = 32'h2000; rs1_addr = 5'd7; sel = 3'd0; in_valid = 1'b1;
        byp_valid = 2'b01; byp_addr = {5'd0, 5'd7}; byp_data = {32'h0, 32'hCAFE}; byp_busy = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ilk_ready%0d: got %b want 0", i, in_ready); end
            tick();
        end
        checks++; if (stall_cnt !== 16'd3 || out_valid !== 1'b0) begin
            errors++; $display("FAIL ilk_cnt: got cnt=%0d v=%b want cnt=3 v=0", stall_cnt, out_valid);
        end
        byp_busy = 2'b00;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ilk_release_ready: got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || to_alu_a !== 32'hCAFE || out_bypassed !== 1'b1 || stall_cnt !== 16'd3) begin
            errors++; $display("FAIL ilk_release: got v=%b d=%h b=%b cnt=%0d want v=1 d=0000cafe b=1 cnt=3", out_valid, to_alu_a, out_bypassed, stall_cnt);
        end
        // Busy channel is irrelevant when the selected source is not rs1.
        byp_busy = 2'b01; sel = 3'd1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ilk_imm_ready: got %b want 1", in_ready); end
        tick();
        checks++; if (to_alu_a !== 32'h2000 || out_bypassed !== 1'b0 || stall_cnt !== 16'd3) begin
            errors++; $display("FAIL ilk_imm: got d=%h b=%b cnt=%0d want d=00002000 b=0 cnt=3", to_alu_a, out_bypassed, stall_cnt);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        clear_inputs();
        sel = 3'd1; imm_u = 32'h1234_5678; in_valid = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || to_alu_a !== 32'h1234_5678) begin
            errors++; $display("FAIL bp_acceptA: got v=%b d=%h want v=1 d=12345678", out_valid, to_alu_a);
        end
        out_ready = 1'b0; imm_u = 32'h9ABC_DEF0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b want 0", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || to_alu_a !== 32'h1234_5678) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=12345678", i, out_valid, to_alu_a);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || to_alu_a !== 32'h9ABC_DEF0) begin
            errors++; $display("FAIL bp_acceptB: got v=%b d=%h want v=1 d=9abcdef0", out_valid, to_alu_a);
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        clear_inputs();
        pulse_reset();
        // Hold a bypassed entry.
        rs1_addr = 5'd5; sel = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
        byp_valid = 2'b01; byp_addr = {5'd0, 5'd5}; byp_data = {32'h0, 32'h77};
        tick();
        checks++; if (out_valid !== 1'b1 || out_bypassed !== 1'b1 || to_alu_a !== 32'h77) begin
            errors++; $display("FAIL fl_hold: got v=%b b=%b d=%h want v=1 b=1 d=00000077", out_valid, out_bypassed, to_alu_a);
        end
        // Flush with a live request that would also interlock.
        flush = 1'b1; byp_busy = 2'b01; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_bypassed !== 1'b0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL fl_kill: got v=%b b=%b cnt=%0d want v=0 b=0 cnt=0", out_valid, out_bypassed, stall_cnt);
        end
        // Re-hold, then reset mid-operation.
        flush = 1'b0; byp_busy = 2'b00; out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || to_alu_a !== 32'h77) begin
            errors++; $display("FAIL fl_rehold: got v=%b d=%h want v=1 d=00000077", out_valid, to_alu_a);
        end
        reset = 1'b1; flush = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || to_alu_a !== 32'h0 || out_bypassed !== 1'b0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL fl_reset: got v=%b d=%h b=%b cnt=%0d want all 0", out_valid, to_alu_a, out_bypassed, stall_cnt);
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        clear_inputs();
        pulse_reset();
        rs1_addr = 5'd9; sel = 3'd0; in_valid = 1'b1;
        byp_valid = 2'b01; byp_addr = {5'd0, 5'd9}; byp_busy = 2'b01;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d want 15", stall_cnt4); end
        checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16: got %0d want 20", stall_cnt); end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_source_select();
        test_bypass();
        test_interlock();
        test_backpressure();
        test_flush();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
